serial_mag_comparator: RTL and testbench
========================================

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are 4..64.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH mod CHUNK SHALL be 0.
REQ-003 SHALL have parameter EARLY_EXIT, default 1; when 1, the comparison ends at the first unequal chunk.
REQ-004 SHALL have parameter SIGNED, default 0; when 1, operands are two's complement.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit, a request to compare a and b.
REQ-008 SHALL have port a, input, WIDTH bits, operand A.
REQ-009 SHALL have port b, input, WIDTH bits, operand B.
REQ-010 SHALL have port busy, output, 1 bit, high while state is RUN.
REQ-011 SHALL have port done, output, 1 bit, a one-cycle result-valid pulse.
REQ-012 SHALL have ports eq, gt, lt, output, 1 bit each, the registered result of the last completed compare.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE, with NCHUNK = WIDTH/CHUNK.
REQ-014 SHALL transition IDLE->RUN when start=1 at a clock edge, and at that edge latch a and b, set the chunk index to NCHUNK-1, and set the running flags e=1, g=0.
REQ-015 SHALL, in each RUN cycle, compare chunk[index] of A and B, MSB chunk first: e_next = e AND (A_c == B_c); g_next = g OR (e AND A_c > B_c).
REQ-016 SHALL leave RUN for DONE when index==0, or when EARLY_EXIT=1 and e_next=0; otherwise decrement index and stay in RUN.
REQ-017 SHALL, on the RUN->DONE edge, write eq=e_next, gt=g_next and lt=NOT e_next AND NOT g_next.
REQ-018 SHALL keep exactly one of eq, gt, lt high after the first completion.
REQ-019 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 SHALL have a latency of NCHUNK edges from the start-sampling edge to done high when no early exit occurs, and k edges when the first unequal chunk is the k-th chunk processed.
REQ-021 SHALL, when SIGNED=1, invert bit WIDTH-1 of both latched operands before comparing; this gives the signed order with no extra cycle.
REQ-022 SHALL ignore start in RUN and DONE; an ignored start is not queued.
REQ-023 SHALL ignore changes on a and b after the latching edge.
REQ-024 SHALL hold eq, gt and lt stable from DONE until the next RUN->DONE edge.
REQ-025 SHALL assert busy=1 exactly while in RUN; done and busy are never high together.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state IDLE, busy=0, done=0, eq=1, gt=0, lt=0, index=0, and clear the operand registers.
REQ-027 SHALL, on reset asserted mid-RUN, abandon the compare with no done pulse; after release the block idles until a new start.
REQ-028 SHALL accept start at the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the state encoding (IDLE=0, RUN=1, DONE=2) and the default parameter constants in package serial_cmp_pkg.
REQ-030 SHALL instantiate one combinational sub-module, chunk_cmp_slice (CHUNK-bit A_c, B_c, e_in, g_in -> e_out, g_out), which generalises the 1-bit cascade comparator cell to CHUNK bits.
REQ-031 SHALL have no other sub-module; the chunk index counter and the FSM are in the top level.

Verification
REQ-032 SHALL pass, with defaults: a=16'h1234, b=16'h1234, start pulse -> done 4 edges later, eq=1, gt=0, lt=0, busy high for 4 cycles.
REQ-033 SHALL pass, with defaults: a=16'h9000, b=16'h1FFF -> early exit, done 1 edge after start, gt=1.
REQ-034 SHALL pass, with EARLY_EXIT=0: a=16'h0001, b=16'h0002 -> done at edge 4, lt=1.
REQ-035 SHALL pass, with SIGNED=1: a=16'hFFFF (-1), b=16'h0001 -> lt=1; with SIGNED=0 the same operands -> gt=1.
REQ-036 SHALL pass: start again mid-RUN -> no effect, only one done pulse; rst_n pulsed low mid-RUN -> no done, outputs at reset values, the next start completes normally.
REQ-037 SHALL pass an exhaustive sweep over all 256 operand pairs with WIDTH=4, CHUNK=1 (all 16 x 16 values), checking every result against a behavioural compare.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared state encoding and default parameters for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWidth     = 16;
  localparam int unsigned DefChunk     = 4;
  localparam int unsigned DefEarlyExit = 1;
  localparam int unsigned DefSigned    = 0;

endpackage

// File: rtl/chunk_cmp_slice.sv
// Combinational cascade cell: folds one CHUNK-bit slice into the running equal/greater flags.
module chunk_cmp_slice
  import serial_cmp_pkg::*;
#(
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             e_in,
  input  logic             g_in,
  output logic             e_out,
  output logic             g_out
);

  always_comb begin
    e_out = e_in & (a_c == b_c);
    g_out = g_in | (e_in & (a_c > b_c));
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first, optionally
// stopping at the first unequal chunk.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned CHUNK      = DefChunk,
  parameter int unsigned EARLY_EXIT = DefEarlyExit,
  parameter int unsigned SIGNED     = DefSigned
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NChunk - 1);
  // Flipping the sign bit of both operands maps two's complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SignMask = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_e                          r_state, w_state_d;
  logic   [WIDTH-1:0]              r_a, r_b, w_a_d, w_b_d;
  logic   [IdxW-1:0]               r_idx, w_idx_d;
  logic                            r_e, r_g, w_e_d, w_g_d;
  logic                            r_eq, r_gt, r_lt, w_eq_d, w_gt_d, w_lt_d;
  logic   [NChunk-1:0][CHUNK-1:0]  w_a_chunks, w_b_chunks;
  logic                            w_e_next, w_g_next, w_finish;

  assign w_a_chunks = r_a;
  assign w_b_chunks = r_b;

  chunk_cmp_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a_c   (w_a_chunks[r_idx]),
    .b_c   (w_b_chunks[r_idx]),
    .e_in  (r_e),
    .g_in  (r_g),
    .e_out (w_e_next),
    .g_out (w_g_next)
  );

  assign w_finish = (r_idx == '0) || ((EARLY_EXIT != 0) && !w_e_next);

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_idx_d   = r_idx;
    w_e_d     = r_e;
    w_g_d     = r_g;
    w_eq_d    = r_eq;
    w_gt_d    = r_gt;
    w_lt_d    = r_lt;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StRun;
          w_a_d     = a ^ SignMask;
          w_b_d     = b ^ SignMask;
          w_idx_d   = LastIdx;
          w_e_d     = 1'b1;
          w_g_d     = 1'b0;
        end
      end
      StRun: begin
        w_e_d = w_e_next;
        w_g_d = w_g_next;
        if (w_finish) begin
          w_state_d = StDone;
          w_eq_d    = w_e_next;
          w_gt_d    = w_g_next;
          w_lt_d    = !w_e_next && !w_g_next;
        end else begin
          w_idx_d = r_idx - IdxW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_e     <= 1'b1;
      r_g     <= 1'b0;
      r_eq    <= 1'b1;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_idx   <= w_idx_d;
      r_e     <= w_e_d;
      r_g     <= w_g_d;
      r_eq    <= w_eq_d;
      r_gt    <= w_gt_d;
      r_lt    <= w_lt_d;
    end
  end

  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: four configurations checked every cycle against an
// arithmetic reference, plus directed vectors with hand-computed results.
module tb_serial_mag_comparator;

  typedef struct packed {
    logic [7:0] lat;
    logic       eq;
    logic       gt;
    logic       lt;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       st = '0;
  logic [3:0][15:0] av = '0;
  logic [3:0][15:0] bv = '0;
  logic [3:0]       bz, dn, oeq, ogt, olt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: EARLY_EXIT=0, 2: SIGNED=1, 3: WIDTH=4 CHUNK=1
  serial_mag_comparator u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]),
    .busy(bz[0]), .done(dn[0]), .eq(oeq[0]), .gt(ogt[0]), .lt(olt[0])
  );
  serial_mag_comparator #(.EARLY_EXIT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]),
    .busy(bz[1]), .done(dn[1]), .eq(oeq[1]), .gt(ogt[1]), .lt(olt[1])
  );
  serial_mag_comparator #(.SIGNED(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
    .busy(bz[2]), .done(dn[2]), .eq(oeq[2]), .gt(ogt[2]), .lt(olt[2])
  );
  serial_mag_comparator #(.WIDTH(4), .CHUNK(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .a(av[3][3:0]), .b(bv[3][3:0]),
    .busy(bz[3]), .done(dn[3]), .eq(oeq[3]), .gt(ogt[3]), .lt(olt[3])
  );

  // Reference: numeric compare of the operands plus position of the first differing chunk.
  function automatic res_t calc(int i, logic [15:0] a_in, logic [15:0] b_in);
    res_t        r;
    int          w, c, n;
    bit          early, sg, found;
    longint      sa, sb;
    logic [15:0] m, cm, x, y;
    case (i)
      0:       begin w = 16; c = 4; early = 1; sg = 0; end
      1:       begin w = 16; c = 4; early = 0; sg = 0; end
      2:       begin w = 16; c = 4; early = 1; sg = 1; end
      default: begin w = 4;  c = 1; early = 1; sg = 0; end
    endcase
    m  = 16'((32'd1 << w) - 32'd1);
    cm = 16'((32'd1 << c) - 32'd1);
    x  = a_in & m;
    y  = b_in & m;
    sa = longint'(x);
    sb = longint'(y);
    if (sg && x[w-1]) sa = sa - (longint'(1) << w);
    if (sg && y[w-1]) sb = sb - (longint'(1) << w);
    n     = w / c;
    r.lat = 8'(n);
    found = 0;
    if (early) begin
      for (int k = 1; k <= n; k++) begin
        if (!found && (((x >> (w - k * c)) & cm) != ((y >> (w - k * c)) & cm))) begin
          r.lat = 8'(k);
          found = 1;
        end
      end
    end
    r.eq = (sa == sb);
    r.gt = (sa > sb);
    r.lt = (sa < sb);
    return r;
  endfunction

  // Cycle-level expectation: phase 0 idle, 1 running (m_cnt edges to go), 2 result pulse.
  int         m_ph  [4] = '{0, 0, 0, 0};
  int         m_cnt [4] = '{0, 0, 0, 0};
  res_t       m_res [4];
  logic [3:0] m_eq = '1;
  logic [3:0] m_gt = '0;
  logic [3:0] m_lt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= '{0, 0, 0, 0};
      m_eq <= '1;
      m_gt <= '0;
      m_lt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (m_ph[i])
          0: if (st[i]) begin
            m_res[i] <= calc(i, av[i], bv[i]);
            m_cnt[i] <= int'(calc(i, av[i], bv[i]).lat);
            m_ph[i]  <= 1;
          end
          1: if (m_cnt[i] <= 1) begin
            m_ph[i] <= 2;
            m_eq[i] <= m_res[i].eq;
            m_gt[i] <= m_res[i].gt;
            m_lt[i] <= m_res[i].lt;
          end else begin
            m_cnt[i] <= m_cnt[i] - 1;
          end
          default: m_ph[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dut%0d busy", i), int'(bz[i]),  int'(m_ph[i] == 1));
      chk($sformatf("dut%0d done", i), int'(dn[i]),  int'(m_ph[i] == 2));
      chk($sformatf("dut%0d eq", i),   int'(oeq[i]), int'(m_eq[i]));
      chk($sformatf("dut%0d gt", i),   int'(ogt[i]), int'(m_gt[i]));
      chk($sformatf("dut%0d lt", i),   int'(olt[i]), int'(m_lt[i]));
    end
  end

  task automatic launch(int i, logic [15:0] a_in, logic [15:0] b_in);
    av[i] = a_in;
    bv[i] = b_in;
    st[i] = 1'b1;
  endtask

  // Called right after launch; returns edges from the start-sampling edge to done high.
  task automatic finish(int i, output int lat, output int nbusy);
    bit got;
    lat   = -1;
    nbusy = 0;
    got   = 0;
    @(negedge clk);
    st[i] = 1'b0;
    av[i] = 16'($urandom);
    bv[i] = 16'($urandom);
    if (bz[i]) nbusy++;
    for (int n = 1; n <= 100; n++) begin
      if (!got) begin
        @(negedge clk);
        if (dn[i]) begin
          lat = n;
          got = 1;
        end else if (bz[i]) begin
          nbusy++;
        end
      end
    end
    if (!got) chk($sformatf("dut%0d done timeout", i), 0, 1);
  endtask

  task automatic run(int i, logic [15:0] a_in, logic [15:0] b_in, output int lat,
                     output int nbusy);
    @(negedge clk);
    launch(i, a_in, b_in);
    finish(i, lat, nbusy);
  endtask

  initial begin
    int lat, nb, ndone;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("reset eq", int'(oeq[0]), 1);
    chk("reset busy", int'(bz[0]), 0);

    run(0, 16'h1234, 16'h1234, lat, nb);
    chk("equal latency", lat, 4);
    chk("equal busy cycles", nb, 4);
    chk("equal eq", int'(oeq[0]), 1);
    chk("equal gt", int'(ogt[0]), 0);
    chk("equal lt", int'(olt[0]), 0);

    run(0, 16'h9000, 16'h1FFF, lat, nb);
    chk("early latency", lat, 1);
    chk("early gt", int'(ogt[0]), 1);

    run(1, 16'h0001, 16'h0002, lat, nb);
    chk("no-early latency", lat, 4);
    chk("no-early lt", int'(olt[1]), 1);

    run(2, 16'hFFFF, 16'h0001, lat, nb);
    chk("signed lt", int'(olt[2]), 1);
    chk("signed latency", lat, 1);
    run(0, 16'hFFFF, 16'h0001, lat, nb);
    chk("unsigned gt", int'(ogt[0]), 1);

    run(1, 16'h8000, 16'h8000, lat, nb);
    chk("no-early equal eq", int'(oeq[1]), 1);
    run(0, 16'h1230, 16'h1231, lat, nb);
    chk("last chunk latency", lat, 4);
    chk("last chunk lt", int'(olt[0]), 1);

    // Second start while running must be dropped.
    @(negedge clk);
    launch(0, 16'h1234, 16'h1235);
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[0]) ndone++;
    end
    chk("restart done pulses", ndone, 1);
    chk("restart lt", int'(olt[0]), 1);

    // Reset mid-run abandons the compare.
    @(negedge clk);
    launch(0, 16'h0001, 16'h0002);
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", int'(bz[0]), 0);
    chk("rst done", int'(dn[0]), 0);
    chk("rst eq", int'(oeq[0]), 1);
    chk("rst lt", int'(olt[0]), 0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (dn[0]) ndone++;
    end
    chk("rst done pulses", ndone, 0);
    rst_n = 1'b1;
    launch(0, 16'h00A0, 16'h00A0);
    finish(0, lat, nb);
    chk("post-rst latency", lat, 4);
    chk("post-rst eq", int'(oeq[0]), 1);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run(3, 16'(x), 16'(y), lat, nb);
        chk($sformatf("sweep eq %0d,%0d", x, y), int'(oeq[3]), int'(x == y));
        chk($sformatf("sweep gt %0d,%0d", x, y), int'(ogt[3]), int'(x > y));
        chk($sformatf("sweep lt %0d,%0d", x, y), int'(olt[3]), int'(x < y));
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
